// File: rtl/mem_hash_sched.sv
// mem_hash_sched: row loader, credit-based admission and result FIFO in front of one mem_hash core.
// Credits return only on downstream pop, so the FIFO can never be pushed while full.
module mem_hash_sched #(
    parameter int N        = 32,
    parameter int M        = 16,
    parameter int ID_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [N*32-1:0]          job_data,
    input  logic [ID_WIDTH-1:0]      job_id,
    output logic                     hash_rst_n,
    output logic                     hash_in_valid,
    output logic [4:0]               hash_in_addr,
    output logic [ID_WIDTH-1:0]      hash_in_index,
    output logic [N*32-1:0]          hash_mem_in,
    input  logic                     hash_out_ready,
    output logic                     hash_in_ready,
    input  logic                     hash_out_valid,
    input  logic [N*32-1:0]          hash_out_hash,
    input  logic [ID_WIDTH-1:0]      hash_out_index,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [N*32-1:0]          res_hash,
    output logic [ID_WIDTH-1:0]      res_id,
    output logic [$clog2(M):0]       credits
);
    localparam int AW = $clog2(M);
    localparam int CW = AW + 1;
    localparam int DW = N * 32 + ID_WIDTH;

    logic [4:0]    beat_q, beat_d;
    logic [CW-1:0] cred_q, cred_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [DW-1:0] fifo_q [M];
    logic          go, acc, take, pop, empty, full;

    assign go    = hash_out_ready && (beat_q != 5'd0 || cred_q != '0) && !rst;
    assign acc   = job_valid && go;
    assign take  = acc && beat_q == 5'd0;
    assign empty = wr_q == rd_q;
    assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign pop   = res_valid && res_ready;

    assign beat_d = acc ? beat_q + 5'd1 : beat_q;
    assign cred_d = cred_q - CW'(take) + CW'(pop);
    assign wr_d   = wr_q + (AW + 1)'(hash_out_valid);
    assign rd_d   = rd_q + (AW + 1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            cred_q <= CW'(M);
            wr_q   <= '0;
            rd_q   <= '0;
        end else begin
            beat_q <= beat_d;
            cred_q <= cred_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hash_out_valid) fifo_q[wr_q[AW-1:0]] <= {hash_out_hash, hash_out_index};
    end

    assign {res_hash, res_id} = fifo_q[rd_q[AW-1:0]];
    assign res_valid     = !empty && !rst;
    assign credits       = rst ? CW'(M) : cred_q;
    assign job_ready     = go;
    assign hash_in_valid = acc;
    assign hash_in_addr  = beat_q;
    assign hash_in_index = job_id;
    assign hash_mem_in   = job_data;
    assign hash_in_ready = !rst;
    assign hash_rst_n    = !rst;

    // A push into a full FIFO without a matching pop would mean the credit invariant broke.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(hash_out_valid && full && !pop));
endmodule

// File: doc/mem_hash_sched.md
# mem_hash_sched

Job scheduler and result collector placed directly in front of one `mem_hash` instance.
- Accepts jobs from an upstream word stream and loads them into the core as 32 scratch rows. Row 31 is the initial state and triggers lane init.
- Throttles admission with a credit counter so no more than M jobs are ever resident, because the core's round-robin lane allocator has no occupancy check.
- Captures every core result into an internal FIFO, because the core has no output backpressure, and presents results downstream with valid/ready.

## Interface
Parameters:
- N, 32, word width in bits per element; a row is N*32 bits. Must match the core.
- M, 16, core lane count, result FIFO depth and credit maximum. Power of two.
- ID_WIDTH, 32, job identifier width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  upstream row valid.
- job_ready  out  1  upstream row accepted when job_valid && job_ready.
- job_data  in  N*32  row payload.
- job_id  in  ID_WIDTH  job identifier; sampled on the job's final (32nd) row.
- hash_rst_n  out  1  core reset, equal to ~rst (combinational).
- hash_in_valid  out  1  to core in_valid.
- hash_in_addr  out  5  to core in_addr; the current row number 0..31.
- hash_in_index  out  ID_WIDTH  to core in_index, equal to job_id.
- hash_mem_in  out  N*32  to core mem_in, equal to job_data.
- hash_out_ready  in  1  from core out_ready.
- hash_in_ready  out  1  to core in_ready; constant 1 outside reset.
- hash_out_valid  in  1  from core out_valid.
- hash_out_hash  in  N*32  from core out_hash.
- hash_out_index  in  ID_WIDTH  from core out_index.
- res_valid  out  1  result available.
- res_ready  in  1  downstream consumes when res_valid && res_ready.
- res_hash  out  N*32  result hash.
- res_id  out  ID_WIDTH  result job id.
- credits  out  $clog2(M)+1  free job slots, range 0..M.

## Operation
- The row counter `beat` is 5 bits and counts 0..31. It increments on each accepted row and wraps from 31 to 0. Wrap-around marks the end of a job.
- Admission gate is `go = hash_out_ready && (beat != 0 || credits != 0) && !rst`.
- Load path, combinational: `job_ready = go`, `hash_in_valid = job_valid && go`, `hash_in_addr = beat`.
- Credit is consumed when row 0 of a job is accepted. Once row 0 is accepted, the job's remaining rows are never credit-blocked; only hash_out_ready can stall them.
- Credit returns when a result is popped downstream (res_valid && res_ready). Credit does not return at core output.
- In-flight accounting: credits + resident jobs + FIFO occupancy + (a partially loaded job) = M at all times. The FIFO therefore can never overflow and the core never holds more than M jobs.
- Consumption and return in the same cycle leave credits unchanged. credits is never below 0 or above M.
- Result capture: every cycle with hash_out_valid=1 is a distinct result. The core clears out_valid after one cycle while in_ready=1. Each such result is pushed into the FIFO as {hash_out_hash, hash_out_index}, without any condition.
- A push while the FIFO is full is impossible by construction. It is flagged by a simulation assertion; RTL drops nothing intentionally.
- FIFO: M entries, registered head. res_valid = !empty; res_hash and res_id come from the head entry. Push and pop in the same cycle are allowed, including when the FIFO is full and when it is empty-after-push.

## Timing
- Reset values: job_ready=0, hash_in_valid=0, hash_in_ready=0, res_valid=0, credits=M, beat=0, FIFO empty.
- After reset: hash_in_ready=1 from the first cycle with rst=0.
- hash_rst_n=0 for exactly the cycles where rst=1. The core and the scheduler therefore reset together.
- Reset mid-job: the partial job is discarded, beat=0, FIFO flushed, credits=M. Resident jobs are lost with the core reset.
- Load latency: zero-cycle pass-through from job_* to hash_*. A 32-row job takes at least 32 cycles.
- Result latency: a core result seen at cycle t gives res_valid=1 at t+1 if the FIFO was empty.
- Credit visibility: credits updates on the edge after the row-0 accept or the pop. A job whose row 0 is offered at cycle t+1 sees the updated value.
- hash_out_ready low stalls any row, including mid-job. beat holds its value while stalled.

## Test plan
- Single job: rows 0..31 with job_id=0x5 and no stalls → hash_in_addr goes 0..31 on consecutive cycles; credits drops to M-1 after row 0. The core result appears with res_id=0x5; credits returns to M one cycle after the pop.
- Oversubscription: M+1 back-to-back jobs, res_ready=0 → job_ready=0 at row 0 of job M+1 once credits=0. The FIFO fills to exactly M results, with no push while full. Raising res_ready for 1 cycle lets job M+1 start on the following cycle.
- Core stall: hash_out_ready forced low for 5 cycles at beat=17 → no row accepted during the stall, beat holds 17, the job resumes with row 17 and the row sequence stays intact.
- Simultaneous pop and admit: credits=0, FIFO full, res_ready=1 and row 0 offered in the same cycle → row 0 is blocked in that cycle and accepted next cycle. credits returns 0→1→0.
- Back-to-back core results on consecutive cycles with res_ready=0 → both captured in order; res_id order matches hash_out_index order.
- Reset mid-job: rst=1 for 1 cycle at beat=9 with 3 results buffered → res_valid=0, credits=M, beat=0, hash_rst_n=0 during that cycle. A fresh job afterwards completes normally.
